guy_sprite_addr_gen: RTL

//  Upstream address stage for the 4-bit palette sprite ROM (3072 x 4b = 3 frames of 32x32).

---
 rtl/guy_sprite_addr_gen_pkg.sv | 23 ++
 rtl/guy_sprite_addr_gen_if.sv | 37 +++
 rtl/guy_sprite_addr_gen_anim_fsm.sv | 80 ++++++++
 rtl/guy_sprite_addr_gen.sv | 97 +++++++++
 4 files changed

// File: rtl/guy_sprite_addr_gen_pkg.sv
// guy_pkg: shared sizes and types for the guy sprite address generator.
//   SPRITE_W/SPRITE_H  sprite dimensions in pixels (both powers of 2)
//   NUM_FRAMES         frames in the sheet: 0 = idle, 1..NUM_FRAMES-1 = walk cycle
//   FRAME_HOLD         frame ticks each walk frame is shown
//   ADDR_W             sprite ROM address width
//   anim_state_t       animation FSM state
//   frame_t            animation frame index
package guy_pkg;

    localparam int unsigned SPRITE_W   = 32;
    localparam int unsigned SPRITE_H   = 32;
    localparam int unsigned NUM_FRAMES = 3;
    localparam int unsigned FRAME_HOLD = 8;
    localparam int unsigned ADDR_W     = 12;

    typedef enum logic {
        ANIM_IDLE,
        ANIM_WALK
    } anim_state_t;

    typedef logic [1:0] frame_t;

endpackage

// File: rtl/guy_sprite_addr_gen_if.sv
// guy_sprite_addr_gen_if: beam/character inputs and ROM-address outputs of
// the guy sprite address generator.
//   frame_clk          vsync-rate level, rising edge = frame tick
//   DrawX, DrawY       current beam pixel
//   GuyX, GuyY         sprite top-left corner
//   moving             character is walking
//   facing_left        mirror request
//   character_address  registered ROM address
//   sprite_on          beam inside sprite box, aligned with ROM data
//   frame_idx          current animation frame
// Modports: master drives the beam/character side, slave is the generator.
interface guy_sprite_addr_gen_if #(
    parameter int unsigned ADDR_W = guy_pkg::ADDR_W
) ();

    logic               frame_clk;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic [9:0]         GuyX;
    logic [9:0]         GuyY;
    logic               moving;
    logic               facing_left;
    logic [ADDR_W-1:0]  character_address;
    logic               sprite_on;
    guy_pkg::frame_t    frame_idx;

    modport master (
        output frame_clk, DrawX, DrawY, GuyX, GuyY, moving, facing_left,
        input  character_address, sprite_on, frame_idx
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, GuyX, GuyY, moving, facing_left,
        output character_address, sprite_on, frame_idx
    );

endinterface

// File: rtl/guy_sprite_addr_gen_anim_fsm.sv
// guy_anim_fsm: walk-animation sequencer for the guy sprite.
//   Clk         pixel/system clock
//   Reset       asynchronous, active-high
//   frame_clk   vsync-rate level synchronous to Clk
//   moving      character is walking
//   frame_tick  one-Clk pulse on the rising edge of frame_clk
//   frame_idx   current animation frame (0 = idle)
// State, hold counter and frame only advance on frame_tick.
module guy_anim_fsm
    import guy_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = guy_pkg::NUM_FRAMES,
    parameter int unsigned FRAME_HOLD = guy_pkg::FRAME_HOLD
) (
    input  logic   Clk,
    input  logic   Reset,
    input  logic   frame_clk,
    input  logic   moving,
    output logic   frame_tick,
    output frame_t frame_idx
);

    localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    logic              frame_clk_q;
    anim_state_t       state, state_n;
    logic [HOLD_W-1:0] hold, hold_n;
    frame_t            frame_n;

    // Edge register resets high so a frame_clk already high at release
    // does not produce a tick.
    assign frame_tick = frame_clk & ~frame_clk_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b1;
            state       <= ANIM_IDLE;
            hold        <= '0;
            frame_idx   <= '0;
        end else begin
            frame_clk_q <= frame_clk;
            state       <= state_n;
            hold        <= hold_n;
            frame_idx   <= frame_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        frame_n = frame_idx;
        if (frame_tick) begin
            unique case (state)
                ANIM_IDLE: begin
                    frame_n = '0;
                    hold_n  = '0;
                    if (moving) begin
                        state_n = ANIM_WALK;
                        frame_n = frame_t'(1);
                    end
                end
                ANIM_WALK: begin
                    // Stopping returns to idle at once, even mid-hold.
                    if (!moving) begin
                        state_n = ANIM_IDLE;
                        frame_n = '0;
                        hold_n  = '0;
                    end else if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
                        hold_n  = '0;
                        frame_n = (frame_idx == frame_t'(NUM_FRAMES - 1))
                                  ? frame_t'(1) : frame_idx + frame_t'(1);
                    end else begin
                        hold_n = hold + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/guy_sprite_addr_gen.sv
// guy_sprite_addr_gen: address stage for the 4-bit palette guy sprite ROM
// (NUM_FRAMES frames of SPRITE_W x SPRITE_H).
//   Clk    pixel/system clock
//   Reset  asynchronous, active-high
//   bus    guy_sprite_addr_gen_if.slave (beam/character in, address out)
// character_address is registered one Clk after DrawX/DrawY; sprite_on is
// the box test delayed two Clk so it lines up with the ROM's registered data.
// GuyX/GuyY/facing_left are sampled only on a frame tick to avoid tearing.
// Build option: GUY_HFLIP_EN mirrors columns when the latched facing_left
// is set; otherwise facing_left is ignored.
module guy_sprite_addr_gen
    import guy_pkg::*;
#(
    parameter int unsigned SPRITE_W   = guy_pkg::SPRITE_W,
    parameter int unsigned SPRITE_H   = guy_pkg::SPRITE_H,
    parameter int unsigned NUM_FRAMES = guy_pkg::NUM_FRAMES,
    parameter int unsigned FRAME_HOLD = guy_pkg::FRAME_HOLD,
    parameter int unsigned ADDR_W     = guy_pkg::ADDR_W
) (
    input logic                 Clk,
    input logic                 Reset,
    guy_sprite_addr_gen_if.slave bus
);

    localparam int unsigned LX_W = $clog2(SPRITE_W);
    localparam int unsigned LY_W = $clog2(SPRITE_H);

    logic              frame_tick;
    frame_t            frame_cur;
    logic [9:0]        gx, gy;
    logic              flip;
    logic [10:0]       x_end, y_end;
    logic              in_box, in_box_q;
    logic [LX_W-1:0]   lx, col;
    logic [LY_W-1:0]   ly;
    logic [ADDR_W-1:0] addr_c;

    guy_anim_fsm #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_anim (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (bus.frame_clk),
        .moving     (bus.moving),
        .frame_tick (frame_tick),
        .frame_idx  (frame_cur)
    );

    assign bus.frame_idx = frame_cur;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gx   <= '0;
            gy   <= '0;
            flip <= 1'b0;
        end else if (frame_tick) begin
            gx   <= bus.GuyX;
            gy   <= bus.GuyY;
`ifdef GUY_HFLIP_EN
            flip <= bus.facing_left;
`endif
        end
    end

`ifndef GUY_HFLIP_EN
    logic unused_facing_left;
    assign unused_facing_left = bus.facing_left;
`endif

    // 11-bit bounds so a sprite near the right/bottom edge does not wrap.
    always_comb begin
        x_end  = {1'b0, gx} + 11'(SPRITE_W);
        y_end  = {1'b0, gy} + 11'(SPRITE_H);
        in_box = (bus.DrawX >= gx) && ({1'b0, bus.DrawX} < x_end) &&
                 (bus.DrawY >= gy) && ({1'b0, bus.DrawY} < y_end);
        lx     = LX_W'(bus.DrawX - gx);
        ly     = LY_W'(bus.DrawY - gy);
        col    = flip ? (LX_W'(SPRITE_W - 1) - lx) : lx;
        addr_c = ADDR_W'(frame_cur) * ADDR_W'(SPRITE_W * SPRITE_H)
               + ADDR_W'(ly) * ADDR_W'(SPRITE_W)
               + ADDR_W'(col);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.character_address <= '0;
            in_box_q              <= 1'b0;
            bus.sprite_on         <= 1'b0;
        end else begin
            bus.character_address <= in_box ? addr_c : '0;
            in_box_q              <= in_box;
            bus.sprite_on         <= in_box_q;
        end
    end

endmodule
